// File: rtl/ifu_fetch_bus_pkg.sv
// ifu_fetch_bus_pkg
//   Shared definitions for the instruction-fetch bus path: FSM state
//   encodings, the default reset PC, the errF codes reported with each
//   fetched instruction and the AXI OKAY response code. Also used by the LSU
//   fetch path and by the decode/exception logic.
package ifu_fetch_bus_pkg;

    typedef enum logic [1:0] {
        S_AR       = 2'd0,
        S_R        = 2'd1,
        S_OUT      = 2'd2,
        S_WAIT_NPC = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BUS      = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // A fetch address is legal only when it is word aligned.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_timeout_cnt.sv
// ifu_timeout_cnt
//   Cycle counter that bounds how long the fetch unit waits for read data.
//   Ports:
//     clk    in  clock
//     rst    in  asynchronous active-low reset
//     clr    in  restart the count from zero (new read issued)
//     en     in  count one more waiting cycle
//     expire out the current waiting cycle is the last one allowed
module ifu_timeout_cnt #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] cnt_r;

    // Cycles already spent waiting; the TIMEOUT-th waiting cycle is the last.
    assign expire = (cnt_r == (TIMEOUT - 16'd1));

    // Wait-cycle counter: clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 16'd0;
        end else if (clr) begin
            cnt_r <= 16'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/ifu_fetch_bus.sv
// ifu_fetch_bus
//   Instruction fetch stage. Owns the PC, issues a single read per
//   instruction over an AR/R channel and hands {instF, pcF, snpcF, errF} to
//   decode with a valid/ready handshake. Only one fetch is ever in flight;
//   the next one starts when writeback supplies the next PC.
//   Ports:
//     clk, rst                    clock, asynchronous active-low reset
//     npc_valid, npc              next PC pulse from writeback
//     arvalid, arready, araddr    read-address channel (araddr == pc)
//     rvalid, rready, rdata, rresp read-data channel
//     m_valid, m_ready            handshake toward decode
//     instF, pcF, snpcF, errF     fetched word, its PC, PC+4, error code
module ifu_fetch_bus
    import ifu_fetch_bus_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [15:0] TIMEOUT  = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic [31:0] snpcF,
    output logic [1:0]  errF
);

    fetch_state_e state_r, next_state_s;
    logic [31:0]  pc_r, next_pc_s;
    logic [31:0]  inst_r, snpc_r;
    logic [1:0]   err_r;
    logic         arvalid_r, rready_r, m_valid_r;

    logic         out_load_s;
    logic [31:0]  inst_val_s;
    logic [1:0]   err_val_s;
    logic         cnt_clr_s, cnt_en_s, expire_s;

    ifu_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_s),
        .en     (cnt_en_s),
        .expire (expire_s)
    );

    // Next-state logic plus the values captured for decode when a fetch ends.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc_r;
        out_load_s   = 1'b0;
        inst_val_s   = 32'd0;
        err_val_s    = ERR_NONE;
        cnt_clr_s    = 1'b0;
        cnt_en_s     = 1'b0;
        case (state_r)
            S_AR: begin
                if (pc_misaligned(pc_r[1:0])) begin
                    // Never put a misaligned address on the bus.
                    out_load_s   = 1'b1;
                    err_val_s    = ERR_MISALIGN;
                    next_state_s = S_OUT;
                end else if (arvalid_r && arready) begin
                    cnt_clr_s    = 1'b1;
                    next_state_s = S_R;
                end else begin
                    next_state_s = S_AR;
                end
            end
            S_R: begin
                if (rvalid && rready_r) begin
                    out_load_s   = 1'b1;
                    inst_val_s   = rdata;
                    err_val_s    = (rresp != RESP_OKAY) ? ERR_BUS : ERR_NONE;
                    next_state_s = S_OUT;
                end else if (expire_s) begin
                    out_load_s   = 1'b1;
                    err_val_s    = ERR_TIMEOUT;
                    next_state_s = S_OUT;
                end else begin
                    cnt_en_s     = 1'b1;
                    next_state_s = S_R;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    next_state_s = S_WAIT_NPC;
                end else begin
                    next_state_s = S_OUT;
                end
            end
            S_WAIT_NPC: begin
                if (npc_valid) begin
                    next_pc_s    = npc;
                    next_state_s = S_AR;
                end else begin
                    next_state_s = S_WAIT_NPC;
                end
            end
            default: begin
                next_state_s = S_AR;
            end
        endcase
    end

    // State, PC, decode-side payload and the registered channel controls.
    // Handshake outputs are flopped from the next state so no input reaches
    // an output combinationally; arvalid stays low for a misaligned PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_AR;
            pc_r      <= RESET_PC;
            inst_r    <= 32'd0;
            snpc_r    <= 32'd0;
            err_r     <= ERR_NONE;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            pc_r      <= next_pc_s;
            arvalid_r <= (next_state_s == S_AR) && !pc_misaligned(next_pc_s[1:0]);
            rready_r  <= (next_state_s == S_R);
            m_valid_r <= (next_state_s == S_OUT);
            if (out_load_s) begin
                inst_r <= inst_val_s;
                err_r  <= err_val_s;
                snpc_r <= pc_r + 32'd4;
            end else begin
                inst_r <= inst_r;
                err_r  <= err_r;
                snpc_r <= snpc_r;
            end
        end
    end

    assign arvalid = arvalid_r;
    assign araddr  = pc_r;
    assign rready  = rready_r;
    assign m_valid = m_valid_r;
    assign instF   = inst_r;
    assign pcF     = pc_r;
    assign snpcF   = snpc_r;
    assign errF    = err_r;

endmodule

// File: tb/tb_ifu_fetch_bus.sv
module tb_ifu_fetch_bus;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        npc_valid;
    logic [31:0] npc;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] instF;
    logic [31:0] pcF;
    logic [31:0] snpcF;
    logic [1:0]  errF;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] snpc;
        logic [1:0]  err;
    } exp_t;

    ifu_fetch_bus #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (16'd16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .npc_valid (npc_valid),
        .npc       (npc),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .instF     (instF),
        .pcF       (pcF),
        .snpcF     (snpcF),
        .errF      (errF)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // Reference: what decode must see for a fetch, from the architectural rules.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] data,
                                   input logic [1:0] resp, input bit timed_out);
        exp_t e;
        e.snpc = pc + 32'd4;
        if (pc % 4 != 0) begin
            e.inst = 32'd0; e.err = 2'd2;
        end else if (timed_out) begin
            e.inst = 32'd0; e.err = 2'd3;
        end else begin
            e.inst = data;  e.err = (resp == 2'd0) ? 2'd0 : 2'd1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input exp_t e);
        chk({tag, ".m_valid"}, m_valid, 32'd1);
        chk({tag, ".instF"},   instF,   e.inst);
        chk({tag, ".pcF"},     pcF,     pc);
        chk({tag, ".snpcF"},   snpcF,   e.snpc);
        chk({tag, ".errF"},    errF,    e.err);
    endtask

    task automatic send_npc(input logic [31:0] pc);
        npc_valid = 1'b1;
        npc       = pc;
        tick();
        npc_valid = 1'b0;
        npc       = 32'd0;
    endtask

    // One complete fetch, starting in S_AR and ending with decode accepting it.
    task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] data,
                         input logic [1:0] resp, input int ar_dly, input int r_dly,
                         input int bp, input bit npc_in_r, input bit timeout_case);
        exp_t e;
        int   n;
        bit   seen;
        e = model(pc, data, resp, timeout_case);
        if (pc % 4 != 0) begin
            n = 0;
            while (!m_valid && n < 10) begin
                chk({tag, ".no_arvalid"}, arvalid, 32'd0);
                n++;
                tick();
            end
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (arvalid) seen = 1'b1;
                else tick();
            end
            chk({tag, ".arvalid_seen"}, seen, 32'd1);
            chk({tag, ".araddr"}, araddr, pc);
            for (int i = 0; i < ar_dly; i++) begin
                tick();
                chk({tag, ".ar_hold"}, {arvalid, araddr[30:0]}, {1'b1, pc[30:0]});
            end
            arready = 1'b1;
            tick();
            arready = 1'b0;
            chk({tag, ".rready"}, rready, 32'd1);
            if (timeout_case) begin
                n = 0;
                while (!m_valid && n < 40) begin
                    n++;
                    tick();
                end
                chk({tag, ".timeout_cycles"}, n, 32'd16);
            end else begin
                for (int i = 0; i < r_dly; i++) begin
                    if (i == 0 && npc_in_r) begin
                        npc_valid = 1'b1;
                        npc       = 32'hA5A5_A5A0;
                    end
                    tick();
                    npc_valid = 1'b0;
                end
                rvalid = 1'b1; rdata = data; rresp = resp;
                tick();
                rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
            end
        end
        check_out(tag, pc, e);
        for (int i = 0; i < bp; i++) begin
            tick();
            check_out({tag, ".bp"}, pc, e);
            chk({tag, ".bp_arvalid"}, arvalid, 32'd0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk({tag, ".drained"}, {arvalid, m_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] rpc, rdat;
        logic [1:0]  rrsp;
        int          ad, rd, bpc;
        bit          nir;

        rst = 1'b0; npc_valid = 1'b0; npc = 32'd0; arready = 1'b0;
        rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0; m_ready = 1'b0;
        tick(); tick();
        chk("reset.arvalid", arvalid, 32'd0);
        chk("reset.rready",  rready,  32'd0);
        chk("reset.m_valid", m_valid, 32'd0);
        chk("reset.instF",   instF,   32'd0);
        chk("reset.snpcF",   snpcF,   32'd0);
        chk("reset.errF",    errF,    32'd0);
        chk("reset.pcF",     pcF,     RST_PC);
        chk("reset.araddr",  araddr,  RST_PC);
        rst = 1'b1;

        fetch("first", RST_PC, 32'h0000_0413, 2'b00, 0, 0, 5, 1'b0, 1'b0);
        send_npc(32'h8000_0010);
        fetch("npc_ign", 32'h8000_0010, 32'h1234_5678, 2'b00, 7, 2, 0, 1'b1, 1'b0);
        send_npc(32'h8000_0014);
        fetch("buserr", 32'h8000_0014, 32'hDEAD_BEEF, 2'b10, 0, 1, 1, 1'b0, 1'b0);
        send_npc(32'h8000_0002);
        fetch("misalign", 32'h8000_0002, 32'h0, 2'b00, 0, 0, 2, 1'b0, 1'b0);
        send_npc(32'h8000_0020);
        fetch("timeout", 32'h8000_0020, 32'h0, 2'b00, 1, 0, 0, 1'b0, 1'b1);
        send_npc(32'hFFFF_FFFC);
        fetch("wrap", 32'hFFFF_FFFC, 32'h0010_0093, 2'b00, 0, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            rpc  = $urandom() & 32'hFFFF_FFFC;
            rdat = $urandom();
            rrsp = 2'($urandom_range(0, 3));
            ad   = $urandom_range(0, 3);
            rd   = $urandom_range(0, 3);
            bpc  = $urandom_range(0, 3);
            nir  = (rd > 0) && ($urandom_range(0, 1) == 1);
            send_npc(rpc);
            fetch("rand", rpc, rdat, rrsp, ad, rd, bpc, nir, 1'b0);
        end

        // Reset asserted while the read is outstanding.
        send_npc(32'h8000_0100);
        chk("midrst.arvalid", arvalid, 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("midrst.in_r", rready, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst.arvalid0", arvalid, 32'd0);
        chk("midrst.rready0",  rready,  32'd0);
        chk("midrst.m_valid0", m_valid, 32'd0);
        chk("midrst.pcF",      pcF,     RST_PC);
        chk("midrst.payload",  instF | snpcF | {30'd0, errF}, 32'd0);
        tick(); tick();
        rst = 1'b1;
        fetch("restart", RST_PC, 32'h0000_0513, 2'b00, 0, 0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
